// File: rtl/index_buf_fifo.sv
// Show-ahead FIFO feeding the per-bit buffer array's `a` bus.
// Latency: a word pushed at edge N is visible on out_data in cycle N+1 (no fall-through while empty).
// Backpressure: in_ready drops while full; out_valid drops while empty. Both are decoded from count only.
//
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   in_data/valid/ready  : producer side, word accepted when valid & ready at the edge
//   out_data/valid/ready : consumer side, out_data is the head word (0 when empty)
//   count                : current occupancy, 0..DEPTH
module index_buf_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;

  // Flow-control flags come straight from the occupancy register, so no
  // input-to-output combinational path exists through the FIFO.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
  end

  always_comb begin
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
  end

  // DEPTH is a power of two, so pointer wrap is just natural ADDR_W-bit overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale contents are hidden by the
  // empty gating on out_data below.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Forced to zero when empty so the downstream buffer array sees a
  // deterministic value instead of a stale entry.
  always_comb begin
    out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

endmodule

// File: tb/tb_index_buf_fifo.sv
module tb_index_buf_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_checks;
  int n_errors;

  index_buf_fifo #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;

    // Reset held two cycles with a push offered: nothing may be enqueued.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'h00);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single word: visible the cycle after the push, then popped.
    push_word(8'hA5);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_data", 32'(out_data), 32'h00);
    chk("single_pop_valid", 32'(out_valid), 32'd0);

    // Fill to full, then offer 0x05 which must be ignored.
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push_word(8'h05);
    chk("full_ignore_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", 32'(out_data), 32'h00);

    // Steady state at count=2 with push+pop every cycle; 12 pushes wrap pointers 3 times.
    push_word(8'h10);
    push_word(8'h11);
    chk("conc_prefill_count", 32'(count), 32'd2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h12 + 8'(k);
      chk("conc_data", 32'(out_data), 32'(8'h10 + 8'(k)));
      step();
      chk("conc_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    chk("conc_tail0", 32'(out_data), 32'h1A);
    step();
    chk("conc_tail1", 32'(out_data), 32'h1B);
    step();
    out_ready = 1'b0;
    chk("conc_empty_count", 32'(count), 32'd0);

    // Full plus pop: first cycle pops only, producer holds 0x24 until accepted.
    for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i));
    chk("fp_full_count", 32'(count), 32'd4);
    in_data   = 8'h24;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("fp_head0", 32'(out_data), 32'h20);
    step();
    chk("fp_pop_only_count", 32'(count), 32'd3);
    chk("fp_in_ready", 32'(in_ready), 32'd1);
    chk("fp_head1", 32'(out_data), 32'h21);
    step();
    in_valid = 1'b0;
    chk("fp_both_count", 32'(count), 32'd3);
    for (int i = 2; i <= 4; i++) begin
      chk("fp_drain", 32'(out_data), 32'(8'h20 + 8'(i)));
      step();
    end
    out_ready = 1'b0;
    chk("fp_empty_count", 32'(count), 32'd0);

    // Mid-operation reset discards queued words; stale storage must stay hidden.
    push_word(8'h30);
    push_word(8'h31);
    push_word(8'h32);
    chk("mr_count", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_count_after", 32'(count), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'h00);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    // Pop attempt while empty must be ignored.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    push_word(8'h3C);
    chk("mr_first_data", 32'(out_data), 32'h3C);
    chk("mr_first_count", 32'(count), 32'd1);
    chk("mr_first_valid", 32'(out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
